// File: rtl/wb_line_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_line_pkg
//  Description : Shared widths, FSM state encoding and the beat-selection
//                helper for the Wishbone line responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_line_pkg;

    localparam int LINE_W     = 128;
    localparam int SEL_W      = 16;
    localparam int ADR_W      = 12;
    localparam int WORD_W     = 32;
    localparam int BEAT_IDX_W = 2;
    localparam int BE_W       = WORD_W / 8;
    localparam int LINE_BEATS = LINE_W / WORD_W;

    // Marker returned when no further beat is enabled (one past the last beat).
    localparam logic [BEAT_IDX_W:0] BEAT_NONE = (BEAT_IDX_W+1)'(LINE_BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Lowest beat index >= from whose byte-enable nibble is non-zero,
    // or BEAT_NONE when there is none.
    function automatic logic [BEAT_IDX_W:0] next_beat(
        input logic [SEL_W-1:0]      mask,
        input logic [BEAT_IDX_W:0]   from
    );
        logic [BEAT_IDX_W:0] idx;
        idx = BEAT_NONE;
        for (int k = LINE_BEATS - 1; k >= 0; k--) begin
            if (k >= int'(from) && mask[BE_W*k +: BE_W] != '0) begin
                idx = (BEAT_IDX_W+1)'(k);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_beat_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_beat_timer
//  Description : Per-beat wait counter. Counts enabled cycles, clears on
//                clear_i, flags expiry on the cycle the count reaches
//                TIMEOUT-1. TIMEOUT = 0 disables expiry entirely.
//  Ports       : clk, rst       - clock, async active-high reset
//                clear_i        - restart the count (beat done / not in beat)
//                enable_i       - a beat is waiting this cycle
//                expired_o      - this waiting cycle is the last allowed one
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_beat_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT != 0) begin : g_timeout_on
            localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (enable_i) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired_o = enable_i && !clear_i && (count_q == LAST);
        end else begin : g_timeout_off
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : wb_line_responder
//  Description : Wishbone slave terminating 128-bit line reads/writes and
//                splitting each into up to four 32-bit memory beats.
//                Ends with a one-cycle ACK, or RTY on a beat timeout.
//  Ports       : wb_*_i / wb_*_o   - Wishbone slave side (line wide)
//                mem_*_o / mem_*_i - word-wide memory port, req/ready handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_line_responder
    import wb_line_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int BEATS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [SEL_W-1:0]        wb_sel_i,
    input  logic [ADR_W-1:0]        wb_adr_i,
    input  logic [LINE_W-1:0]       wb_dat_m_i,
    output logic [LINE_W-1:0]       wb_dat_s_o,
    output logic                    wb_ack_o,
    output logic                    wb_rty_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADR_W+BEAT_IDX_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0]       mem_wdata_o,
    output logic [BE_W-1:0]         mem_be_o,
    input  logic [WORD_W-1:0]       mem_rdata_i,
    input  logic                    mem_ready_i
);

    localparam int BUF_W = WORD_W * BEATS;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [ADR_W-1:0]       adr_q, adr_d;
    logic [SEL_W-1:0]       mask_q, mask_d;     // beat enables; all ones for reads
    logic [LINE_W-1:0]      dat_q, dat_d;
    logic [BEAT_IDX_W-1:0]  k_q, k_d;
    logic [BUF_W-1:0]       buf_q, buf_d;
    logic                   rty_q, rty_d;
    logic                   abort_q, abort_d;   // master dropped cyc mid-transaction

    logic                   in_beat;
    logic                   expired;
    logic [BEAT_IDX_W:0]    first_k;
    logic [BEAT_IDX_W:0]    next_k;
    logic [SEL_W-1:0]       req_mask;

    assign in_beat  = (state_q == BEAT);
    assign req_mask = wb_we_i ? wb_sel_i : '1;
    assign first_k  = next_beat(req_mask, '0);
    assign next_k   = next_beat(mask_q, {1'b0, k_q} + 1'b1);

    wb_beat_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!in_beat || mem_ready_i),
        .enable_i  (in_beat),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        mask_d  = mask_q;
        dat_d   = dat_q;
        k_d     = k_q;
        buf_d   = buf_q;
        rty_d   = rty_q;
        abort_d = abort_q;

        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d    = wb_we_i;
                    adr_d   = wb_adr_i;
                    mask_d  = req_mask;
                    dat_d   = wb_dat_m_i;
                    rty_d   = 1'b0;
                    abort_d = 1'b0;
                    if (first_k == BEAT_NONE) begin
                        state_d = DONE;     // write with no enabled bytes
                    end else begin
                        k_d     = first_k[BEAT_IDX_W-1:0];
                        state_d = BEAT;
                    end
                end
            end
            BEAT: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (mem_ready_i) begin
                    if (!we_q) begin
                        buf_d[WORD_W*k_q +: WORD_W] = mem_rdata_i;
                    end
                    if (next_k == BEAT_NONE) begin
                        state_d = (abort_q || !wb_cyc_i) ? IDLE : DONE;
                    end else if (abort_q || !wb_cyc_i) begin
                        state_d = IDLE;     // in-flight beat finished, stop here
                    end else begin
                        k_d = next_k[BEAT_IDX_W-1:0];
                    end
                end else if (expired) begin
                    rty_d   = 1'b1;
                    state_d = (abort_q || !wb_cyc_i) ? IDLE : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            mask_q  <= '0;
            dat_q   <= '0;
            k_q     <= '0;
            buf_q   <= '0;
            rty_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            mask_q  <= mask_d;
            dat_q   <= dat_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
            rty_q   <= rty_d;
            abort_q <= abort_d;
        end
    end

    // Memory-side outputs are held at zero outside a beat.
    assign mem_req_o   = in_beat;
    assign mem_we_o    = in_beat && we_q;
    assign mem_addr_o  = in_beat ? {adr_q, k_q} : '0;
    assign mem_wdata_o = in_beat ? dat_q[WORD_W*k_q +: WORD_W] : '0;
    assign mem_be_o    = in_beat ? mask_q[BE_W*k_q +: BE_W] : '0;

    assign wb_ack_o    = (state_q == DONE) && !rty_q;
    assign wb_rty_o    = (state_q == DONE) && rty_q;
    assign wb_dat_s_o  = buf_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_line_responder
//  Description : Directed, scoreboard-driven bench for wb_line_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_line_responder;
    import wb_line_pkg::*;

    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_cyc, wb_stb, wb_we;
    logic [15:0]   wb_sel;
    logic [11:0]   wb_adr;
    logic [127:0]  wb_dat_m, wb_dat_s;
    logic          wb_ack, wb_rty;
    logic          mem_req, mem_we, mem_ready;
    logic [13:0]   mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    logic          stall_en;
    logic [1:0]    stall_k;

    always #5 clk = ~clk;

    wb_line_responder #(.TIMEOUT(TO), .BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_sel_i(wb_sel), .wb_adr_i(wb_adr), .wb_dat_m_i(wb_dat_m),
        .wb_dat_s_o(wb_dat_s), .wb_ack_o(wb_ack), .wb_rty_o(wb_rty),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        if (a[13:2] == 12'h0A3) return 32'h1111_0000 + {30'b0, a[1:0]};
        return {16'hA5A5, 2'b00, a};
    endfunction

    assign mem_rdata = mem_word(mem_addr);
    assign mem_ready = !(stall_en && mem_addr[1:0] == stall_k);

    typedef struct packed {
        logic [13:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    typedef struct packed {
        logic         rty;
        logic         chk;
        logic [127:0] data;
    } resp_t;

    beat_t  beat_q[$];
    resp_t  resp_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     ack_cnt  = 0;
    int     rty_cnt  = 0;
    int     req_k1   = 0;
    logic [127:0] last_line = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory-side scoreboard: every completed beat is matched in order.
    always @(negedge clk) begin : mon_beat
        beat_t b;
        if (!rst && mem_req && mem_ready) begin
            if (beat_q.size() == 0) begin
                check("beat_unexpected", {114'b0, mem_addr}, 128'hFFFF);
            end else begin
                b = beat_q.pop_front();
                check("beat_addr", {114'b0, mem_addr}, {114'b0, b.addr});
                check("beat_we",   {127'b0, mem_we},   {127'b0, b.we});
                check("beat_be",   {124'b0, mem_be},   {124'b0, b.be});
                if (b.we) check("beat_wdata", {96'b0, mem_wdata}, {96'b0, b.wdata});
            end
        end
    end

    // Wishbone-side scoreboard.
    always @(negedge clk) begin : mon_resp
        resp_t r;
        if (wb_ack || wb_rty) begin
            check("ack_rty_excl", {127'b0, wb_ack && wb_rty}, 128'b0);
            if (wb_ack) ack_cnt++; else rty_cnt++;
            if (resp_q.size() == 0) begin
                check("resp_unexpected", {126'b0, wb_ack, wb_rty}, 128'b0);
            end else begin
                r = resp_q.pop_front();
                check("resp_kind", {127'b0, wb_rty}, {127'b0, r.rty});
                if (r.chk) check("resp_data", wb_dat_s, r.data);
            end
        end
    end

    // Push the beats and the ACK the specification requires for a transaction.
    task automatic expect_txn(input logic we, input logic [15:0] sel,
                              input logic [11:0] adr, input logic [127:0] dat);
        beat_t b;
        resp_t r;
        logic [127:0] line;
        line = last_line;
        for (int k = 0; k < 4; k++) begin
            if (!we || sel[4*k +: 4] != 4'h0) begin
                b.addr  = {adr, 2'(k)};
                b.we    = we;
                b.wdata = dat[32*k +: 32];
                b.be    = we ? sel[4*k +: 4] : 4'hF;
                beat_q.push_back(b);
                if (!we) line[32*k +: 32] = mem_word(b.addr);
            end
        end
        r.rty  = 1'b0;
        r.chk  = 1'b1;
        r.data = line;
        resp_q.push_back(r);
        last_line = line;
    endtask

    task automatic start(input logic we, input logic [15:0] sel,
                         input logic [11:0] adr, input logic [127:0] dat);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_m = dat;
        @(posedge clk); #1;        // sample edge
        wb_stb = 1'b0;
    endtask

    // Waits (bounded) for ACK/RTY; latency counted in cycles after the sample edge.
    task automatic wait_resp(input string tag, input int exp_lat);
        int n;
        bit got;
        n = 0; got = 0; req_k1 = 0;
        while (n < 50 && !got) begin
            @(negedge clk);
            n++;
            if (mem_req && mem_addr[1:0] == 2'd1) req_k1++;
            if (wb_ack || wb_rty) got = 1;
        end
        if (!got) check({tag, "_no_response"}, 128'd0, 128'd1);
        else if (exp_lat >= 0) check({tag, "_latency"}, 128'(n), 128'(exp_lat));
        @(posedge clk); #1;
        wb_cyc = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_beats_left"}, 128'(beat_q.size()), 128'd0);
        check({tag, "_resp_left"},  128'(resp_q.size()), 128'd0);
    endtask

    initial begin
        int n;
        int acks0;
        rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0;
        wb_sel = '0; wb_adr = '0; wb_dat_m = '0;
        stall_en = 1'b0; stall_k = 2'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack",   {127'b0, wb_ack},  128'd0);
        check("rst_rty",   {127'b0, wb_rty},  128'd0);
        check("rst_req",   {127'b0, mem_req}, 128'd0);
        check("rst_mem",   {78'b0, mem_we, mem_addr, mem_wdata, mem_be}, 128'd0);
        check("rst_dat_s", wb_dat_s, 128'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Full read, memory always ready
        expect_txn(1'b0, 16'h0000, 12'h0A3, '0);
        start(1'b0, 16'h0000, 12'h0A3, '0);
        wait_resp("read_a3", 5);
        check("read_a3_line", last_line, 128'h11110003_11110002_11110001_11110000);
        check_drained("read_a3");

        // Sparse writes; buffer must be left untouched
        expect_txn(1'b1, 16'h0F0F, 12'h010, 128'hDDDD_CCCC_BBBB_AAAA);
        start(1'b1, 16'h0F0F, 12'h010, 128'hDDDD_CCCC_BBBB_AAAA);
        wait_resp("write_0f0f", 3);
        check_drained("write_0f0f");

        expect_txn(1'b1, 16'hF0A0, 12'h7FF, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        start(1'b1, 16'hF0A0, 12'h7FF, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        wait_resp("write_f0a0", 3);
        check_drained("write_f0a0");

        // Write with no byte enables: no beats, DONE follows the sample edge
        expect_txn(1'b1, 16'h0000, 12'h055, 128'hFFFF);
        start(1'b1, 16'h0000, 12'h055, 128'hFFFF);
        wait_resp("write_sel0", 1);
        check_drained("write_sel0");

        // Strobe held over DONE: one transaction per sample
        acks0 = ack_cnt;
        expect_txn(1'b0, 16'h0000, 12'h155, '0);
        expect_txn(1'b0, 16'h0000, 12'h155, '0);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 12'h155;
        @(posedge clk); #1;
        n = 0;
        while (n < 50 && !wb_ack) begin @(negedge clk); n++; end
        check("held_first_latency", 128'(n), 128'd5);
        repeat (3) @(posedge clk);
        #1 wb_stb = 1'b0;
        wait_resp("held_second", -1);
        check("held_ack_count", 128'(ack_cnt - acks0), 128'd2);
        check_drained("held");

        // Beat 1 never ready: retry after TO waiting cycles
        stall_en = 1'b1; stall_k = 2'd1;
        begin : to_exp
            beat_t b;
            resp_t r;
            b.addr = {12'h3C5, 2'd0}; b.we = 1'b0; b.wdata = '0; b.be = 4'hF;
            beat_q.push_back(b);
            r.rty = 1'b1; r.chk = 1'b0; r.data = '0;
            resp_q.push_back(r);
        end
        start(1'b0, 16'h0000, 12'h3C5, '0);
        wait_resp("timeout", 2 + TO);
        check("timeout_k1_cycles", 128'(req_k1), 128'(TO));
        @(negedge clk);
        check("timeout_idle_req", {127'b0, mem_req}, 128'd0);
        check("timeout_idle_rty", {126'b0, wb_ack, wb_rty}, 128'd0);
        check_drained("timeout");
        stall_en = 1'b0;

        // Master abort during the first beat: finish it, then no response
        acks0 = ack_cnt + rty_cnt;
        stall_en = 1'b1; stall_k = 2'd0;
        begin : ab_exp
            beat_t b;
            b.addr = {12'h222, 2'd0}; b.we = 1'b0; b.wdata = '0; b.be = 4'hF;
            beat_q.push_back(b);
        end
        start(1'b0, 16'h0000, 12'h222, '0);
        wb_cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1 stall_en = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_req", {127'b0, mem_req}, 128'd0);
        check("abort_no_resp", 128'(ack_cnt + rty_cnt - acks0), 128'd0);
        check_drained("abort");

        // Asynchronous reset in the middle of beat 2
        stall_en = 1'b1; stall_k = 2'd2;
        expect_txn(1'b0, 16'h0000, 12'h0A3, '0);
        start(1'b0, 16'h0000, 12'h0A3, '0);
        n = 0;
        while (n < 20 && !(mem_req && mem_addr[1:0] == 2'd2)) begin @(negedge clk); n++; end
        check("rst_mid_reached_beat2", {127'b0, mem_req && mem_addr[1:0] == 2'd2}, 128'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req", {127'b0, mem_req}, 128'd0);
        check("rst_mid_resp", {126'b0, wb_ack, wb_rty}, 128'd0);
        beat_q.delete();
        resp_q.delete();
        last_line = '0;
        @(posedge clk); #1;
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; stall_en = 1'b0;

        expect_txn(1'b0, 16'h0000, 12'h0A3, '0);
        start(1'b0, 16'h0000, 12'h0A3, '0);
        wait_resp("post_rst_read", 5);
        check_drained("post_rst_read");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
